demux64_wr_array: RTL and testbench

- 64-entry x WIDTH storage array, the write-side counterpart of the 64:1 read selection used across the core.
- A 6-bit index is decoded one-hot (6-to-64) to steer write data into exactly one entry. A per-entry valid bit is maintained alongside the data.
- A single combinational read port exposes any entry.
- A sequential flush sweep clears all valid bits, one per cycle. Used for physical-register ready/data storage and pipeline flush recovery.

---
 rtl/demux64_wr_array.sv | 112 +++++++++++
 tb/tb_demux64_wr_array.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux64_wr_array.sv
// 64-entry x WIDTH storage array with a one-hot decoded write port, per-entry valid bits,
// a combinational read port and a sequential valid-clear flush sweep.
module demux64_wr_array #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [5:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             inv_en,
  input  logic [5:0]       inv_idx,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  input  logic [5:0]       rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  output logic [63:0]      vld_vec
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [63:0]      r_vld;
  logic [WIDTH-1:0] r_mem [64];

  logic             w_in_flush;
  logic             w_wr_fire;
  logic [63:0]      w_wr_dec;
  logic [63:0]      w_inv_dec;
  logic [63:0]      w_swp_dec;

  assign w_in_flush = (r_state == ST_FLUSH);
  // Reset is folded into wr_ready so no write can be seen as accepted while held in reset.
  assign wr_ready   = rst_aL & ~w_in_flush;
  assign w_wr_fire  = wr_valid & wr_ready;
  assign flush_busy = w_in_flush;
  assign flush_done = w_in_flush & (r_cnt == 6'd63);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (flush_req) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_cnt == 6'd63) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Sweep pointer; wraps 63 -> 0 on the final sweep edge so IDLE always sees 0.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_cnt <= 6'd0;
    end else if (w_in_flush) begin
      r_cnt <= r_cnt + 6'd1;
    end else if (flush_req) begin
      r_cnt <= 6'd0;
    end
  end

  always_comb begin
    w_wr_dec  = '0;
    w_inv_dec = '0;
    w_swp_dec = '0;
    for (int i = 0; i < 64; i++) begin
      w_wr_dec[i]  = w_wr_fire & (wr_idx == 6'(i));
      w_inv_dec[i] = inv_en & ~w_in_flush & (inv_idx == 6'(i));
      w_swp_dec[i] = w_in_flush & (r_cnt == 6'(i));
    end
  end

  // Invalidate and sweep clears are applied after the write set, so a same-index invalidate wins.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_vld <= '0;
    end else begin
      r_vld <= (r_vld | w_wr_dec) & ~w_inv_dec & ~w_swp_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      // NOTE: the data array is deliberately reset, since entries must read back as zero after reset.
      for (int i = 0; i < 64; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (w_wr_dec[i]) r_mem[i] <= wr_data;
      end
    end
  end

  assign rd_data = r_mem[rd_idx];
  assign rd_vld  = r_vld[rd_idx];
  assign vld_vec = r_vld;

endmodule

// File: tb/tb_demux64_wr_array.sv
// Self-checking bench for demux64_wr_array: directed scenarios plus random traffic
// compared every cycle against a behavioural array/sweep model.
module tb_demux64_wr_array;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_aL;
  logic             wr_valid;
  logic             wr_ready;
  logic [5:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             inv_en;
  logic [5:0]       inv_idx;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;
  logic [5:0]       rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             rd_vld;
  logic [63:0]      vld_vec;

  demux64_wr_array #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_aL     (rst_aL),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .inv_en     (inv_en),
    .inv_idx    (inv_idx),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
    .vld_vec    (vld_vec)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: array contents, valid flags, and sweep progress (entries already cleared).
  logic [WIDTH-1:0] m_data [64];
  bit               m_vld  [64];
  bit               m_busy;
  int               m_swept;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = m_vld[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_data[i] = '0;
      m_vld[i]  = 1'b0;
    end
    m_busy  = 1'b0;
    m_swept = 0;
  endtask

  // Applies the effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    if (m_busy) begin
      m_vld[m_swept] = 1'b0;
      m_swept++;
      if (m_swept == 64) begin
        m_busy  = 1'b0;
        m_swept = 0;
      end
    end else begin
      if (wr_valid) begin
        m_data[wr_idx] = wr_data;
        m_vld[wr_idx]  = 1'b1;
      end
      if (inv_en) m_vld[inv_idx] = 1'b0;
      if (flush_req) begin
        m_busy  = 1'b1;
        m_swept = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("wr_ready",   wr_ready,   rst_aL && !m_busy);
    check("flush_busy", flush_busy, m_busy);
    check("flush_done", flush_done, m_busy && m_swept == 63);
    check("rd_data",    rd_data,    m_data[rd_idx]);
    check("rd_vld",     rd_vld,     m_vld[rd_idx]);
    check("vld_vec",    vld_vec,    model_vec());
  endtask

  // Inputs are set after a falling edge; outputs checked, then one rising edge is taken.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    if (rst_aL) model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    wr_valid  = 1'b0;
    inv_en    = 1'b0;
    flush_req = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] fill5;
    logic [53:0]      hi_ones;
    bit               busy_hist [132];
    int               win1, gap, win2, j;

    rst_aL  = 1'b0;
    set_idle();
    wr_idx  = '0;
    wr_data = '0;
    inv_idx = '0;
    rd_idx  = '0;
    model_reset();
    hi_ones = '1;

    // Reset state
    #1;
    check("rst_wr_ready",   wr_ready,   1'b0);
    check("rst_flush_busy", flush_busy, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_vld_vec",    vld_vec,    64'd0);
    check("rst_rd_data",    rd_data,    32'd0);
    @(negedge clk);
    cycle();
    rst_aL = 1'b1;

    // Writes to both extreme indices
    wr_valid = 1'b1; wr_idx = 6'd0;  wr_data = 32'hA5A5A5A5; cycle();
    wr_idx = 6'd63; wr_data = 32'h12345678; cycle();
    set_idle();
    rd_idx = 6'd63;
    #1;
    check("idx63_data", rd_data, 32'h12345678);
    check("idx63_vld",  rd_vld,  1'b1);
    check("vec_0_63",   vld_vec, 64'h8000_0000_0000_0001);
    cycle();

    // Same-index write and invalidate: data written, invalidate wins
    wr_valid = 1'b1; wr_idx = 6'd17; wr_data = 32'hDEADBEEF;
    inv_en = 1'b1; inv_idx = 6'd17; rd_idx = 6'd17;
    cycle();
    set_idle();
    #1;
    check("same_idx_data", rd_data, 32'hDEADBEEF);
    check("same_idx_vld",  rd_vld,  1'b0);
    wr_valid = 1'b1; wr_idx = 6'd18; wr_data = 32'h18181818; cycle();
    wr_idx = 6'd17; wr_data = 32'h17171717; inv_en = 1'b1; inv_idx = 6'd18;
    cycle();
    set_idle();
    #1;
    check("diff_idx_17", vld_vec[17], 1'b1);
    check("diff_idx_18", vld_vec[18], 1'b0);
    cycle();

    // Fill all entries
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1; wr_idx = 6'(i); wr_data = $urandom;
      cycle();
    end
    fill5 = m_data[5];
    set_idle();
    #1;
    check("filled_vec", vld_vec, {64{1'b1}});

    // One-cycle flush request; a write on the entering edge is still accepted
    flush_req = 1'b1; wr_valid = 1'b1; wr_idx = 6'd2; wr_data = 32'h22222222;
    cycle();
    flush_req = 1'b0; wr_idx = 6'd5; wr_data = 32'hCAFEF00D; rd_idx = 6'd5;
    for (int k = 0; k < 64; k++) begin
      #1;
      check("sweep_busy",  flush_busy, 1'b1);
      check("sweep_ready", wr_ready,   1'b0);
      check("sweep_done",  flush_done, k == 63);
      if (k == 10) check("mid_sweep_hi", 64'(vld_vec[63:10]), 64'(hi_ones));
      cycle();
    end
    #1;
    check("post_sweep_vec",  vld_vec,    64'd0);
    check("post_sweep_busy", flush_busy, 1'b0);
    check("no_write_in_flush", rd_data, fill5);
    cycle();
    set_idle();
    #1;
    check("write_after_flush_data", rd_data, 32'hCAFEF00D);
    check("write_after_flush_vld",  rd_vld,  1'b1);
    for (int i = 0; i < 64; i++) begin
      rd_idx = 6'(i);
      cycle();
    end

    // Reset asserted mid-sweep between edges
    flush_req = 1'b1; cycle();
    flush_req = 1'b0;
    for (int k = 0; k < 30; k++) cycle();
    rst_aL = 1'b0;
    #1;
    model_reset();
    check("midrst_busy",  flush_busy, 1'b0);
    check("midrst_vec",   vld_vec,    64'd0);
    check("midrst_ready", wr_ready,   1'b0);
    @(negedge clk);
    rst_aL = 1'b1;
    wr_valid = 1'b1; wr_idx = 6'd3; wr_data = 32'h33333333; rd_idx = 6'd3;
    cycle();
    set_idle();
    #1;
    check("post_rst_wr_data", rd_data, 32'h33333333);
    check("post_rst_wr_vld",  rd_vld,  1'b1);

    // Flush request held across two sweeps
    flush_req = 1'b1;
    for (int k = 0; k < 132; k++) begin
      if (k == 70) flush_req = 1'b0;
      #1;
      busy_hist[k] = flush_busy;
      cycle();
    end
    j = 0;
    while (j < 132 && !busy_hist[j]) j++;
    win1 = 0;
    while (j < 132 && busy_hist[j]) begin win1++; j++; end
    gap = 0;
    while (j < 132 && !busy_hist[j]) begin gap++; j++; end
    win2 = 0;
    while (j < 132 && busy_hist[j]) begin win2++; j++; end
    check("b2b_window1", 64'(win1), 64'd64);
    check("b2b_gap",     64'(gap),  64'd1);
    check("b2b_window2", 64'(win2), 64'd64);

    // Random traffic against the model
    for (int k = 0; k < 500; k++) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_idx    = 6'($urandom_range(0, 63));
      wr_data   = $urandom;
      inv_en    = ($urandom_range(0, 3) == 0);
      inv_idx   = ($urandom_range(0, 3) == 0) ? wr_idx : 6'($urandom_range(0, 63));
      flush_req = ($urandom_range(0, 59) == 0);
      rd_idx    = ($urandom_range(0, 1) == 1) ? wr_idx : 6'($urandom_range(0, 63));
      cycle();
    end
    set_idle();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
